down_counter_ctrl: RTL and testbench
====================================

Name: down_counter_ctrl

Overview:
Loadable down-counter with a small control FSM. It is the consuming end of the 3-bit up-counter used in the datapath. It is loaded with an iteration count, decrements on each count_down strobe, and signals completion with a one-cycle done pulse. Sequential multiply/divide controllers use it as their iteration counter. Counter bits are built only from the existing T_FF cell (clk, resetn, T, Q), so the toggle-based style stays uniform across the codebase.

Parameters:
WIDTH, 3, counter width in bits (legal range 2..8)

Ports:
clk  input  1  rising-edge clock, the only clock
resetn  input  1  asynchronous, active-low reset
start  input  1  request: load load_val and begin counting; single-cycle pulse expected
load_val  input  WIDTH  initial count, sampled when start is accepted
count_down  input  1  decrement enable, honoured only in RUN
count  output  WIDTH  current counter value
busy  output  1  high in RUN
zero  output  1  combinational, (count == 0)
done  output  1  one-cycle pulse in state DONE

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, count=0, busy=0, done=0, zero=1. Reset takes effect immediately, even mid-RUN. It dominates start.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary; the FSM register has an asynchronous active-low reset.
- IDLE:
  - start=1 and load_val!=0 -> next count=load_val, next state RUN.
  - start=1 and load_val==0 -> count=0, next state DONE. Zero-length job; done follows start by 1 cycle.
  - start=0 -> hold.
- RUN:
  - busy=1.
  - count_down=1 -> count decrements by 1.
  - Transition: if count==1 and count_down=1, next count=0 and next state DONE.
  - count_down=0 -> hold value and state.
  - start is ignored in RUN. No reload and no error.
- DONE:
  - done=1 for exactly this cycle. count=0, busy=0.
  - Next state is IDLE unconditionally.
  - start in DONE is ignored. Back-to-back jobs need start in the cycle after done, i.e. in IDLE.
- Latency:
  - load_val=N (N>0) with count_down held high: done asserts N cycles after the start cycle (start sampled at edge 0, done is high during cycle N).
  - With gaps in count_down: done follows the N-th accepted decrement by 1 cycle.
- Counter implementation, bit i is one T_FF:
  - Decrement: T_i = count_down_en & (all bits below i are 0). Bit 0 toggles on every enabled decrement.
  - Load: T_i = Q_i XOR load_val_i, so no separate D path is needed.
  - Load takes priority over decrement. They are mutually exclusive by FSM construction anyway.
  - count_down_en = count_down & (state==RUN).
- Wrap-around: never occurs. Decrement from 0 is impossible because RUN exits at 1->0. A decrement strobe in IDLE or DONE does not change count.
- Widths: count is unsigned WIDTH bits. load_val of all-ones gives the maximum job length of 2^WIDTH-1 decrements.
- Outputs busy and done are decoded from registered state (glitch-free). zero is combinational from count.

Decomposition:
- Shared package: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, and the default width constant.
- One sub-module: down_counter_core. It holds the WIDTH T_FF instances plus the toggle/load logic, with ports clk, resetn, load, load_val, dec, q.
- The FSM and output decode stay in down_counter_ctrl.
- T_FF is reused unmodified.

Test Plan:
- Reset mid-RUN: load 5, decrement twice, pull resetn low between edges -> count=0, busy=0, done=0 immediately. Release -> IDLE, zero=1.
- Basic countdown: start with load_val=3, count_down held 1 -> count 3,2,1,0. busy high for 3 cycles. done high in cycle 4 only, then IDLE.
- Gapped decrement: load_val=4, count_down pattern 1,0,0,1,1,0,1 -> count holds during the gaps. done asserts 1 cycle after the 4th accepted strobe.
- Zero load: start with load_val=0 -> busy never asserts. done pulses 1 cycle after start. count stays 0.
- Ignored inputs: start with load_val=7 during RUN at count=4 -> count continues 4->3, no reload. count_down pulses in IDLE and DONE leave count at 0.
- Max value and back-to-back: load_val=7 with continuous decrement -> done on cycle 7. start with load_val=2 in the cycle after done -> second job completes and done pulses again 2 cycles later.

Source files
------------

// File: rtl/down_counter_ctrl_pkg.sv
// rtl/down_counter_ctrl_pkg.sv - shared state encoding and width default for down_counter_ctrl
package down_counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/T_FF.sv
// rtl/T_FF.sv - toggle flip-flop cell with asynchronous active-low reset
module T_FF (
  input  logic clk,
  input  logic resetn,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/down_counter_core.sv
// rtl/down_counter_core.sv - loadable down-counter built from T_FF cells
module down_counter_core
  import down_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lower_zero;
  logic [WIDTH-1:0] t;

  // A bit borrows (toggles) on decrement only when every bit below it is 0.
  assign lower_zero[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_borrow
      assign lower_zero[gi] = ~|q[gi-1:0];
    end
  endgenerate

  // Loading toggles exactly the bits that differ from load_val.
  assign t = load ? (q ^ load_val) : ({WIDTH{dec}} & lower_zero);

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      T_FF u_tff (
        .clk    (clk),
        .resetn (resetn),
        .T      (t[gi]),
        .Q      (q[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/down_counter_ctrl.sv
// rtl/down_counter_ctrl.sv - iteration down-counter with IDLE/RUN/DONE control FSM
module down_counter_ctrl
  import down_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_down,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  state_e state_q, state_d;
  logic   busy_q, done_q;
  logic   load_en;
  logic   dec_en;

  assign load_en = start & (state_q == S_IDLE);
  assign dec_en  = count_down & (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (load_val != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (count_down && (count == WIDTH'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_en),
    .load_val (load_val),
    .dec      (dec_en),
    .q        (count)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// tb/tb_down_counter_ctrl.sv - directed self-checking bench for down_counter_ctrl
module tb_down_counter_ctrl;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [2:0] load_val;
  logic       count_down;
  logic [2:0] count;
  logic       busy;
  logic       zero;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  down_counter_ctrl #(.WIDTH(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .load_val   (load_val),
    .count_down (count_down),
    .count      (count),
    .busy       (busy),
    .zero       (zero),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; load_val = 3'd0; count_down = 1'b0;
    cyc();
    n_cmp++;
    if ({count, busy, done, zero} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d busy=%b done=%b zero=%b want 0 0 0 1", count, busy, done, zero);
    end
    resetn = 1'b1;
    cyc();
    start = 1'b1; load_val = 3'd5;
    cyc();
    start = 1'b0; count_down = 1'b1;
    n_cmp++;
    if ({count, busy} !== {3'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_load5: got count=%0d busy=%b want 5 1", count, busy);
    end
    cyc();
    cyc();
    n_cmp++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_pre_dec: got count=%0d want 3", count);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({count, busy, done, zero} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_run: got count=%0d busy=%b done=%b zero=%b want 0 0 0 1", count, busy, done, zero);
    end
    count_down = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if ({count, busy, done, zero} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release_idle: got count=%0d busy=%b done=%b zero=%b want 0 0 0 1", count, busy, done, zero);
    end
  endtask

  task automatic test_basic();
    logic [2:0] ec [5];
    logic [4:0] eb;
    logic [4:0] ed;
    ec = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    eb = 5'b00111;
    ed = 5'b01000;
    start = 1'b1; load_val = 3'd3; count_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      n_cmp++;
      if ({count, busy, done} !== {ec[i], eb[i], ed[i]}) begin
        n_fail++;
        $display("FAIL basic_step%0d: got count=%0d busy=%b done=%b want %0d %b %b",
                 i, count, busy, done, ec[i], eb[i], ed[i]);
      end
    end
    count_down = 1'b0;
  endtask

  task automatic test_gapped();
    logic [6:0] pat;
    logic [2:0] ec [7];
    logic [6:0] eb;
    logic [6:0] ed;
    pat = 7'b1011001;
    ec  = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0};
    eb  = 7'b0111111;
    ed  = 7'b1000000;
    start = 1'b1; load_val = 3'd4; count_down = 1'b0;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({count, busy} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL gapped_load: got count=%0d busy=%b want 4 1", count, busy);
    end
    for (int i = 0; i < 7; i++) begin
      count_down = pat[i];
      cyc();
      n_cmp++;
      if ({count, busy, done} !== {ec[i], eb[i], ed[i]}) begin
        n_fail++;
        $display("FAIL gapped_step%0d: got count=%0d busy=%b done=%b want %0d %b %b",
                 i, count, busy, done, ec[i], eb[i], ed[i]);
      end
    end
    count_down = 1'b0;
    cyc();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL gapped_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_zero_load();
    start = 1'b1; load_val = 3'd0; count_down = 1'b0;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done, zero} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load_done: got count=%0d busy=%b done=%b zero=%b want 0 0 1 1", count, busy, done, zero);
    end
    cyc();
    n_cmp++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_load_after: got count=%0d busy=%b done=%b want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_ignored();
    start = 1'b1; load_val = 3'd7; count_down = 1'b0;
    cyc();
    start = 1'b0; count_down = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL ignored_at4: got count=%0d want 4", count);
    end
    start = 1'b1; load_val = 3'd7;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({count, busy} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL ignored_no_reload: got count=%0d busy=%b want 3 1", count, busy);
    end
    cyc(); cyc(); cyc();
    n_cmp++;
    if ({count, done} !== {3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ignored_done: got count=%0d done=%b want 0 1", count, done);
    end
    start = 1'b1; load_val = 3'd5;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignored_start_in_done: got count=%0d busy=%b done=%b want 0 0 0", count, busy, done);
    end
    cyc(); cyc();
    n_cmp++;
    if ({count, busy, zero} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ignored_dec_in_idle: got count=%0d busy=%b zero=%b want 0 0 1", count, busy, zero);
    end
    count_down = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; load_val = 3'd7; count_down = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      n_cmp++;
      if ({count, done} !== {3'(7 - i), (i == 7)}) begin
        n_fail++;
        $display("FAIL max_step%0d: got count=%0d done=%b want %0d %b", i, count, done, 7 - i, (i == 7));
      end
    end
    cyc();
    start = 1'b1; load_val = 3'd2;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {3'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_load: got count=%0d busy=%b done=%b want 2 1 0", count, busy, done);
    end
    cyc();
    n_cmp++;
    if ({count, done} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_mid: got count=%0d done=%b want 1 0", count, done);
    end
    cyc();
    n_cmp++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_done: got count=%0d busy=%b done=%b want 0 0 1", count, busy, done);
    end
    count_down = 1'b0;
    cyc();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_pulse: got done=%b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero_load();
    test_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
